seq_loop_ctrl: RTL and testbench
================================

# seq_loop_ctrl

Sequencing controller for a single sequential (non-pipelined) HLS-style loop. It accepts a start handshake with a trip count and walks the loop FSM through pre-loop, per-iteration body states, an optional early-quit state and post-loop. It drives the datapath enables and the iteration index, and exposes the loop state on `cur_state` for the simulation loop monitor. The controller sits between the top-level block handshake and the loop body datapath.

## Interface
- `FSM_WIDTH`, 4, width of `cur_state`; must satisfy BODY_STATES+4 <= 2^FSM_WIDTH
- `CNT_WIDTH`, 16, width of trip count and iteration index
- `BODY_STATES`, 3, states per iteration, 1..2^FSM_WIDTH-4

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request to run the loop; sampled only in IDLE
- `trip_count`  in  CNT_WIDTH  iterations to run; latched when `start` is accepted
- `body_stall`  in  1  datapath not ready; holds the current body state
- `exit_req`  in  1  data-dependent break; sampled in the last body state only
- `cur_state`  out  FSM_WIDTH  state register value
- `body_en`  out  1  high in body states when `body_stall`=0
- `iter_idx`  out  CNT_WIDTH  current iteration, 0-based
- `iter_first` / `iter_last`  out  1  `iter_idx`==0 / `iter_idx`==latched count-1, gated by body state
- `quit`  out  1  high in QUIT state
- `idle`  out  1  high in IDLE
- `ready`  out  1  one-cycle pulse in PRE (inputs consumed)
- `done`  out  1  one-cycle pulse in POST

## Operation
- State encoding: IDLE=0, PRE=1, BODY_k=2+k (k=0..BODY_STATES-1), QUIT=BODY_STATES+2, POST=BODY_STATES+3.
- IDLE: if `start`=1, latch `trip_count` and go to PRE. Otherwise stay.
- PRE: clear `iter_idx`. If latched count==0, go to POST; else go to BODY_0.
- BODY_k, k<last: if `body_stall`=1, hold; else go to BODY_k+1.
- BODY_last, `body_stall`=0:
  - If `exit_req`=1, go to QUIT. Exit takes priority even on the final iteration.
  - Else, if `iter_idx`==count-1, go to POST.
  - Else, increment `iter_idx` and go to BODY_0.
- When BODY_STATES=1, BODY_0 is also BODY_last.
- `body_stall`=1 in BODY_last: hold the state; `exit_req` is ignored that cycle.
- QUIT: one cycle, then POST. `iter_idx` is frozen at the quitting iteration.
- POST: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored (no queueing). If `start` is held high, the loop relaunches: POST → IDLE → PRE, with one IDLE cycle between runs.
- `iter_idx` wrap: count uses the full CNT_WIDTH range. count=2^CNT_WIDTH-1 runs to completion with no overflow. The increment never occurs on the final iteration.
- Outputs: `cur_state` and `iter_idx` are registered; all other outputs are combinational decodes of the state register, `iter_idx` and `body_stall`.

## Timing
- Reset values: `cur_state`=0 (IDLE), `iter_idx`=0, latched count=0, `idle`=1, all other outputs 0.
- Reset asserted mid-run returns to IDLE immediately (asynchronous). No `done` is produced for the aborted run.
- No stalls, count N>0, `start` high in cycle 0: PRE in cycle 1, body in cycles 2..N·B+1, POST with `done` in cycle N·B+2, IDLE in cycle N·B+3. B = BODY_STATES.
- N=0: PRE in cycle 1, POST with `done` in cycle 2.
- Each stalled cycle adds exactly one cycle of latency.
- Quit after iteration j (0-based): QUIT in cycle (j+1)·B+2, POST in cycle (j+1)·B+3.

## Configuration
- `SEQ_LOOP_CTRL_PROF_EN` defined:
  - Adds output `busy_cycles` (32 bits). It counts cycles with `idle`=0, saturating at 2^32-1.
  - Cleared on reset and on each accepted `start`.
  - Holds its value while in IDLE.
- Macro undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- B=3, N=4, no stall, `start` pulsed in cycle 0 -> `done` in cycle 14 only; `iter_idx` sequence 0,1,2,3; `iter_first` only in cycles 2–4; `iter_last` only in cycles 11–13.
- N=0 -> PRE in cycle 1, POST with `done`=1 in cycle 2; `body_en` never asserted.
- N=5, `exit_req`=1 in BODY_last of iteration 1 -> QUIT in cycle 8, `done` in cycle 9, `iter_idx`=1 at `done`.
- N=2, `body_stall` high for 3 cycles in BODY_1 of iteration 0 -> `done` in cycle 11; `body_en`=0 during the stall; `cur_state`=3 held.
- `start` held high continuously with N=1 -> `done` pulses in cycles 5 and 11. Reset dropped during BODY_2 -> `cur_state`=0 and `idle`=1 immediately, with no `done`.
- With `SEQ_LOOP_CTRL_PROF_EN`, N=4, B=3, no stall -> `busy_cycles`=14 once back in IDLE.

Source files
------------

// File: rtl/seq_loop_ctrl.sv
// Sequencing controller for one sequential HLS loop: PRE, BODY_0..BODY_last, optional QUIT, POST.
// Define SEQ_LOOP_CTRL_PROF_EN to add the saturating busy_cycles profiling counter.
module seq_loop_ctrl #(
   parameter int unsigned FSM_WIDTH   = 4,
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned BODY_STATES = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] trip_count,
   input  logic                 body_stall,
   input  logic                 exit_req,
   output logic [FSM_WIDTH-1:0] cur_state,
   output logic                 body_en,
   output logic [CNT_WIDTH-1:0] iter_idx,
   output logic                 iter_first,
   output logic                 iter_last,
   output logic                 quit,
   output logic                 idle,
   output logic                 ready,
   output logic                 done
`ifdef SEQ_LOOP_CTRL_PROF_EN
   ,
   output logic [31:0]          busy_cycles
`endif
);

   localparam logic [FSM_WIDTH-1:0] S_IDLE      = '0;
   localparam logic [FSM_WIDTH-1:0] S_PRE       = FSM_WIDTH'(1);
   localparam logic [FSM_WIDTH-1:0] S_BODY_0    = FSM_WIDTH'(2);
   localparam logic [FSM_WIDTH-1:0] S_BODY_LAST = FSM_WIDTH'(BODY_STATES + 1);
   localparam logic [FSM_WIDTH-1:0] S_QUIT      = FSM_WIDTH'(BODY_STATES + 2);
   localparam logic [FSM_WIDTH-1:0] S_POST      = FSM_WIDTH'(BODY_STATES + 3);
   localparam logic [FSM_WIDTH-1:0] FSM_ONE     = FSM_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

   logic [FSM_WIDTH-1:0] state_q, state_d;
   logic [CNT_WIDTH-1:0] iter_q, iter_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 in_body;
   logic                 at_last_iter;

   assign in_body      = (state_q >= S_BODY_0) && (state_q <= S_BODY_LAST);
   // count is never zero while in a body state, so count-1 cannot underflow there
   assign at_last_iter = (iter_q == (count_q - CNT_ONE));

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_PRE;
               count_d = trip_count;
            end
         end
         S_PRE: begin
            iter_d  = '0;
            state_d = (count_q == '0) ? S_POST : S_BODY_0;
         end
         S_QUIT: state_d = S_POST;
         S_POST: state_d = S_IDLE;
         default: begin
            if (!in_body) begin
               state_d = S_IDLE;
            end else if (!body_stall) begin
               if (state_q != S_BODY_LAST) begin
                  state_d = state_q + FSM_ONE;
               end else if (exit_req) begin
                  state_d = S_QUIT;
               end else if (at_last_iter) begin
                  state_d = S_POST;
               end else begin
                  iter_d  = iter_q + CNT_ONE;
                  state_d = S_BODY_0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         count_q <= count_d;
      end
   end

   assign cur_state  = state_q;
   assign iter_idx   = iter_q;
   assign body_en    = in_body && !body_stall;
   assign iter_first = in_body && (iter_q == '0);
   assign iter_last  = in_body && at_last_iter;
   assign quit       = (state_q == S_QUIT);
   assign idle       = (state_q == S_IDLE);
   assign ready      = (state_q == S_PRE);
   assign done       = (state_q == S_POST);

`ifdef SEQ_LOOP_CTRL_PROF_EN
   logic [31:0] busy_q;

   // Counts every non-IDLE cycle of the current run; frozen while idle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
      end else if (state_q == S_IDLE) begin
         if (start) begin
            busy_q <= '0;
         end
      end else if (busy_q != '1) begin
         busy_q <= busy_q + 32'd1;
      end
   end

   assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_seq_loop_ctrl.sv
// Self-checking bench for seq_loop_ctrl: directed scenarios plus randomized runs against a
// slot-walking reference model (iteration x body-slot, with stalls repeating a slot).
module tb_seq_loop_ctrl;

   localparam int FW = 4;
   localparam int CW = 5;
   localparam int B  = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] trip_count = '0;
   logic          body_stall = 1'b0;
   logic          exit_req = 1'b0;
   logic [FW-1:0] cur_state;
   logic          body_en;
   logic [CW-1:0] iter_idx;
   logic          iter_first;
   logic          iter_last;
   logic          quit;
   logic          idle;
   logic          ready;
   logic          done;
`ifdef SEQ_LOOP_CTRL_PROF_EN
   logic [31:0]   busy_cycles;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int m_iter = 0;
   int d;

   seq_loop_ctrl #(
      .FSM_WIDTH  (FW),
      .CNT_WIDTH  (CW),
      .BODY_STATES(B)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .trip_count (trip_count),
      .body_stall (body_stall),
      .exit_req   (exit_req),
      .cur_state  (cur_state),
      .body_en    (body_en),
      .iter_idx   (iter_idx),
      .iter_first (iter_first),
      .iter_last  (iter_last),
      .quit       (quit),
      .idle       (idle),
      .ready      (ready),
      .done       (done)
`ifdef SEQ_LOOP_CTRL_PROF_EN
      ,
      .busy_cycles(busy_cycles)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Outputs packed as {state, iter, body_en, first, last, quit, idle, ready, done}
   task automatic chk_out(input string tag, input int st, input int it, input bit en,
                          input bit fi, input bit la, input bit qu, input bit id,
                          input bit rd, input bit dn);
      logic [FW+CW+6:0] got, exp;
      got = {cur_state, iter_idx, body_en, iter_first, iter_last, quit, idle, ready, done};
      exp = {FW'(st), CW'(it), en, fi, la, qu, id, rd, dn};
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic noise(input bit hold);
      start      = hold ? 1'b1 : 1'($urandom % 2);
      trip_count = CW'($urandom);
      body_stall = 1'($urandom % 2);
      exit_req   = 1'($urandom % 2);
   endtask

   // One run starting from IDLE; returns the cycle of done relative to the start cycle
   task automatic run(input int n, input int exit_iter, input int stall_pct, input int st_iter,
                      input int st_k, input int st_len, input bit hold, output int done_at);
      int  c = 0;
      int  left = st_len;
      bit  quitting = 0;
      bit  stl, ex;
      @(negedge clock);
      noise(hold);
      start = 1'b1;
      trip_count = CW'(n);
      #1 chk_out("idle", 0, m_iter, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clock);
      c++;
      noise(hold);
      #1 chk_out("pre", 1, m_iter, 0, 0, 0, 0, 0, 1, 0);
      m_iter = 0;
      for (int i = 0; i < n && !quitting; i++) begin
         for (int k = 0; k < B; k++) begin
            do begin
               @(negedge clock);
               c++;
               noise(hold);
               stl = ($urandom_range(99) < stall_pct);
               if (i == st_iter && k == st_k && left > 0) begin
                  stl = 1;
                  left--;
               end
               body_stall = stl;
               ex = (k == B - 1) ? (i == exit_iter) : 1'($urandom % 2);
               exit_req = ex;
               m_iter = i;
               #1 chk_out("body", 2 + k, i, !stl, i == 0, i == n - 1, 0, 0, 0, 0);
            end while (stl);
            if (k == B - 1 && ex) quitting = 1;
         end
      end
      if (quitting) begin
         @(negedge clock);
         c++;
         noise(hold);
         #1 chk_out("quit", B + 2, m_iter, 0, 0, 0, 1, 0, 0, 0);
      end
      @(negedge clock);
      c++;
      noise(hold);
      #1 chk_out("post", B + 3, m_iter, 0, 0, 0, 0, 0, 0, 1);
      done_at = c;
   endtask

   initial begin
      // Reset state
      #1 chk_out("rst", 0, 0, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1 chk_out("rst_rel", 0, 0, 0, 0, 0, 0, 1, 0, 0);

      // N=4, no stall
      run(4, -1, 0, -1, 0, 0, 0, d);
      chk_val("done_n4", d, 14);
`ifdef SEQ_LOOP_CTRL_PROF_EN
      @(negedge clock);
      start = 1'b0;
      #1 chk_val("busy_n4", busy_cycles, 14);
      @(negedge clock);
      #1 chk_val("busy_hold", busy_cycles, 14);
`endif

      // N=0
      run(0, -1, 0, -1, 0, 0, 0, d);
      chk_val("done_n0", d, 2);

      // N=5, exit in iteration 1
      run(5, 1, 0, -1, 0, 0, 0, d);
      chk_val("done_quit", d, 9);
      chk_val("iter_quit", iter_idx, 1);

      // N=2, 3 stall cycles in BODY_1 of iteration 0
      run(2, -1, 0, 0, 1, 3, 0, d);
      chk_val("done_stall", d, 11);

      // start held high: back-to-back runs with one IDLE cycle between
      run(1, -1, 0, -1, 0, 0, 1, d);
      chk_val("done_hold0", d, 5);
      run(1, -1, 0, -1, 0, 0, 1, d);
      chk_val("done_hold1", d, 5);

      // Reset during BODY_2
      @(negedge clock);
      start = 1'b1;
      trip_count = CW'(3);
      body_stall = 1'b0;
      exit_req = 1'b0;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      #1 chk_out("pre_abort", 4, 0, 1, 1, 0, 0, 0, 0, 0);
      #1 reset = 1'b0;
      #1 chk_out("abort", 0, 0, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clock);
      #1 chk_out("abort_hold", 0, 0, 0, 0, 0, 0, 1, 0, 0);
      reset = 1'b1;
      m_iter = 0;

      // Full-range trip count
      run((1 << CW) - 1, -1, 0, -1, 0, 0, 0, d);
      chk_val("done_max", d, ((1 << CW) - 1) * B + 2);

      // Randomized runs
      for (int r = 0; r < 40; r++) begin
         int n, ex_it;
         n = ($urandom % 8 == 0) ? (1 << CW) - 1 : $urandom_range(0, 9);
         ex_it = ($urandom % 3 == 0) ? $urandom_range(0, n) : -1;
         run(n, ex_it, $urandom_range(0, 30), -1, 0, 0, 1'($urandom % 2), d);
      end

      @(negedge clock);
      start = 1'b0;
      #1 chk_out("final_idle", 0, m_iter, 0, 0, 0, 0, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
